// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: state encoding and limits.
package dmem_pkg;

    localparam int unsigned DMEM_DEPTH_LOG2 = 6;
    localparam logic [7:0]  DROP_CNT_MAX    = 8'hFF;

    // Encoding 2'd3 is never produced and is decoded as IDLE by the FSM.
    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_LOAD  = 2'd2
    } dmem_state_e;

endpackage

// File: rtl/dmem_array.sv
// Word storage: one synchronous write port, one asynchronous read port, no reset.
module dmem_array #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned DEPTH_LOG2 = 6
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);

    logic [WIDTH-1:0] mem_q [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/dmem_responder.sv
// CPU data-memory responder with post-reset sequential clear and a valid/ready
// streaming loader; CPU traffic is honoured only while idle.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned DEPTH_LOG2     = DMEM_DEPTH_LOG2,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DEPTH_LOG2-1:0] dmem_addr,
    input  logic                  dmem_w_en,
    input  logic [WIDTH-1:0]      dmem_wdata,
    output logic [WIDTH-1:0]      dmem_rdata,
    input  logic                  load_start,
    input  logic [DEPTH_LOG2-1:0] load_base,
    input  logic                  load_valid,
    input  logic [WIDTH-1:0]      load_data,
    input  logic                  load_last,
    output logic                  load_ready,
    output logic                  mem_ready,
    output logic [7:0]            drop_cnt
);

    localparam dmem_state_e           RST_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = 1;

    dmem_state_e           state_q, state_d;
    logic [DEPTH_LOG2-1:0] clr_cnt_q, clr_cnt_d;
    logic [DEPTH_LOG2-1:0] load_ptr_q, load_ptr_d;
    logic [7:0]            drop_cnt_q, drop_cnt_d;
    logic                  load_ready_q, load_ready_d;
    logic                  mem_ready_q, mem_ready_d;

    logic                  wr_en;
    logic [DEPTH_LOG2-1:0] wr_addr;
    logic [WIDTH-1:0]      wr_data;
    logic [WIDTH-1:0]      rd_data;
    logic                  cpu_drop;

    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        load_ptr_d = load_ptr_q;
        drop_cnt_d = drop_cnt_q;
        wr_en      = 1'b0;
        wr_addr    = dmem_addr;
        wr_data    = dmem_wdata;
        cpu_drop   = 1'b0;

        // The single write port is owned by whichever source the state selects.
        case (state_q)
            ST_CLEAR: begin
                wr_en     = 1'b1;
                wr_addr   = clr_cnt_q;
                wr_data   = '0;
                clr_cnt_d = clr_cnt_q + PTR_ONE;
                cpu_drop  = dmem_w_en;
                if (clr_cnt_q == '1) begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                wr_en    = load_valid & load_ready_q;
                wr_addr  = load_ptr_q;
                wr_data  = load_data;
                cpu_drop = dmem_w_en;
                if (load_valid & load_ready_q) begin
                    load_ptr_d = load_ptr_q + PTR_ONE;
                    if (load_last) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                wr_en = dmem_w_en;
                if (load_start) begin
                    state_d    = ST_LOAD;
                    load_ptr_d = load_base;
                end
            end
        endcase

        if (cpu_drop && (drop_cnt_q != DROP_CNT_MAX)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end

        load_ready_d = (state_d == ST_LOAD);
        mem_ready_d  = (state_d != ST_LOAD) && (state_d != ST_CLEAR);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= RST_STATE;
            clr_cnt_q    <= '0;
            load_ptr_q   <= '0;
            drop_cnt_q   <= '0;
            load_ready_q <= 1'b0;
            mem_ready_q  <= !CLEAR_ON_RESET;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            load_ptr_q   <= load_ptr_d;
            drop_cnt_q   <= drop_cnt_d;
            load_ready_q <= load_ready_d;
            mem_ready_q  <= mem_ready_d;
        end
    end

    dmem_array #(
        .WIDTH      (WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (dmem_addr),
        .rd_data (rd_data)
    );

    assign dmem_rdata = (state_q == ST_CLEAR) ? '0 : rd_data;
    assign load_ready = load_ready_q;
    assign mem_ready  = mem_ready_q;
    assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a reference memory image produces read
// expectations that are queued and compared when the DUT read port is sampled.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  dmem_addr = '0;
    logic        dmem_w_en = 1'b0;
    logic [31:0] dmem_wdata = '0;
    logic [31:0] dmem_rdata;
    logic        load_start = 1'b0;
    logic [5:0]  load_base = '0;
    logic        load_valid = 1'b0;
    logic [31:0] load_data = '0;
    logic        load_last = 1'b0;
    logic        load_ready;
    logic        mem_ready;
    logic [7:0]  drop_cnt;

    dmem_responder #(
        .WIDTH          (32),
        .DEPTH_LOG2     (6),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .dmem_addr  (dmem_addr),
        .dmem_w_en  (dmem_w_en),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .load_start (load_start),
        .load_base  (load_base),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_last  (load_last),
        .load_ready (load_ready),
        .mem_ready  (mem_ready),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  addr;
        logic [31:0] exp;
    } rd_exp_t;

    int unsigned err_cnt = 0;
    int unsigned chk_cnt = 0;
    logic [31:0] ref_mem [64];
    logic [5:0]  mptr;
    int unsigned exp_drop;
    rd_exp_t     sb [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_rd(input logic [5:0] a);
        rd_exp_t e;
        e.addr = a;
        e.exp  = ref_mem[a];
        sb.push_back(e);
    endtask

    task automatic drain(input string tag);
        rd_exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            dmem_addr = e.addr;
            #1;
            check_eq(tag, dmem_rdata, e.exp);
        end
    endtask

    task automatic do_reset(input bit poke_start);
        int unsigned n;
        int unsigned nz;
        n  = 0;
        nz = 0;
        dmem_w_en  = 1'b0;
        load_valid = 1'b0;
        load_last  = 1'b0;
        load_start = 1'b0;
        dmem_addr  = 6'd5;
        reset = 1'b1;
        #1;
        check_eq("rst_mem_ready", mem_ready, 0);
        check_eq("rst_load_ready", load_ready, 0);
        check_eq("rst_drop_cnt", drop_cnt, 0);
        check_eq("rst_rdata", dmem_rdata, 0);
        step();
        step();
        reset = 1'b0;
        while (!mem_ready && n < 100) begin
            @(posedge clk);
            n++;
            #1;
            if (!mem_ready && dmem_rdata !== 32'h0) nz++;
            load_start = poke_start && (n == 10);
            load_base  = 6'd0;
        end
        load_start = 1'b0;
        check_eq("clear_edges", n, 64);
        check_eq("clear_rdata_nonzero_cycles", nz, 0);
        check_eq("clear_load_ready", load_ready, 0);
        for (int i = 0; i < 64; i++) ref_mem[i] = '0;
        exp_drop = 0;
    endtask

    task automatic start_burst(input logic [5:0] base);
        load_start = 1'b1;
        load_base  = base;
        step();
        load_start = 1'b0;
        mptr = base;
    endtask

    task automatic beat(input logic [31:0] d, input bit last);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        step();
        ref_mem[mptr] = d;
        mptr = mptr + 6'd1;
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic cpu_write(input logic [5:0] a, input logic [31:0] d);
        dmem_addr  = a;
        dmem_w_en  = 1'b1;
        dmem_wdata = d;
        #1;
        check_eq("wr_same_cycle_old", dmem_rdata, ref_mem[a]);
        step();
        dmem_w_en = 1'b0;
        ref_mem[a] = d;
        expect_rd(a);
        drain("wr_next_cycle_new");
    endtask

    initial begin
        #1;
        check_eq("init_mem_ready", mem_ready, 0);
        check_eq("init_load_ready", load_ready, 0);
        do_reset(1'b0);

        start_burst(6'd4);
        check_eq("pre_load_ready", load_ready, 1);
        check_eq("pre_mem_ready", mem_ready, 0);
        beat(32'h1111_0004, 1'b0);
        beat(32'h5555_5555, 1'b1);
        check_eq("pre_end_load_ready", load_ready, 0);
        expect_rd(6'd4);
        expect_rd(6'd5);
        drain("preload");

        do_reset(1'b1);
        expect_rd(6'd5);
        expect_rd(6'd4);
        drain("post_clear");

        cpu_write(6'd10, 32'hDEAD_BEEF);

        start_burst(6'd62);
        beat(32'hAAAA_0001, 1'b0);
        beat(32'hBBBB_0002, 1'b0);
        beat(32'hCCCC_0003, 1'b0);
        beat(32'hDDDD_0004, 1'b1);
        check_eq("wrap_load_ready", load_ready, 0);
        check_eq("wrap_mem_ready", mem_ready, 1);
        expect_rd(6'd62);
        expect_rd(6'd63);
        expect_rd(6'd0);
        expect_rd(6'd1);
        drain("wrap");

        start_burst(6'd20);
        beat(32'h2020_2020, 1'b0);
        for (int i = 0; i < 3; i++) begin
            dmem_addr  = 6'd3;
            dmem_w_en  = 1'b1;
            dmem_wdata = $urandom;
            step();
            exp_drop++;
        end
        dmem_w_en = 1'b0;
        check_eq("bp_drop_cnt", drop_cnt, exp_drop);
        check_eq("bp_load_ready", load_ready, 1);
        beat(32'h2121_2121, 1'b1);
        expect_rd(6'd3);
        expect_rd(6'd20);
        expect_rd(6'd21);
        expect_rd(6'd22);
        drain("backpressure");

        dmem_addr  = 6'd7;
        dmem_w_en  = 1'b1;
        dmem_wdata = 32'hCAFE_0007;
        load_start = 1'b1;
        load_base  = 6'd7;
        step();
        dmem_w_en  = 1'b0;
        load_start = 1'b0;
        ref_mem[7] = 32'hCAFE_0007;
        mptr = 6'd7;
        check_eq("simul_load_ready", load_ready, 1);
        expect_rd(6'd7);
        drain("simul_cpu");
        beat(32'h0000_0001, 1'b1);
        check_eq("simul_mem_ready", mem_ready, 1);
        expect_rd(6'd7);
        drain("simul_beat");

        start_burst(6'd40);
        beat(32'h4040_0001, 1'b0);
        beat(32'h4040_0002, 1'b0);
        do_reset(1'b0);
        expect_rd(6'd40);
        expect_rd(6'd41);
        drain("midburst_cleared");

        start_burst(6'd50);
        dmem_addr = 6'd9;
        dmem_w_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            dmem_wdata = $urandom;
            step();
            if (exp_drop < 255) exp_drop++;
        end
        dmem_w_en = 1'b0;
        check_eq("sat_drop_cnt", drop_cnt, exp_drop);
        beat(32'h5050_5050, 1'b1);
        expect_rd(6'd9);
        expect_rd(6'd50);
        drain("sat_mem");
        cpu_write(6'd9, 32'h0909_0909);
        check_eq("idle_write_no_drop", drop_cnt, exp_drop);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the CPU data-memory port: a 64 x 32 word store.
- Accepts the CPU's word address, write enable and write data, and returns read data combinationally in the same cycle, as the MEM stage requires.
- Adds a sequential clear after reset and a streaming loader port (valid/ready) that bench or boot logic uses to preload memory before or between runs.
- Sits beside cpu at the top level and connects directly to its dmem_* ports.

Parameters:
- WIDTH, 32, data word width.
- DEPTH_LOG2, 6, address width; depth = 2^DEPTH_LOG2 = 64 words.
- CLEAR_ON_RESET, 1, when 1 memory is zeroed sequentially after reset; when 0 reset goes straight to IDLE.

Ports:
- clk  in  1  clock; all writes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- dmem_addr  in  DEPTH_LOG2  CPU word address (byte address bits [7:2]).
- dmem_w_en  in  1  CPU write enable.
- dmem_wdata  in  WIDTH  CPU write data.
- dmem_rdata  out  WIDTH  CPU read data, combinational from dmem_addr.
- load_start  in  1  one-cycle pulse that begins a load burst.
- load_base  in  DEPTH_LOG2  first word address of the burst, sampled with load_start.
- load_valid  in  1  loader word valid.
- load_data  in  WIDTH  loader word.
- load_last  in  1  marks the final word of a burst; qualified by valid & ready.
- load_ready  out  1  high while in LOAD.
- mem_ready  out  1  high in IDLE; CPU traffic is honoured only in IDLE.
- drop_cnt  out  8  saturating count of CPU writes dropped outside IDLE.

Behaviour:
- Reset values:
  - CLEAR_ON_RESET=1: state=CLEAR, clr_cnt=0, load_ptr=0, drop_cnt=0, load_ready=0, mem_ready=0.
  - CLEAR_ON_RESET=0: state=IDLE, so mem_ready=1.
  - The storage array itself is not reset.
- States:
  - CLEAR: each edge writes mem[clr_cnt]=0 and increments clr_cnt. The edge that writes address 63 moves to IDLE, so mem_ready rises after exactly 64 edges from reset release. dmem_rdata=0 while in CLEAR.
  - IDLE: on an edge with dmem_w_en=1, mem[dmem_addr] <= dmem_wdata. load_start=1 moves to LOAD with load_ptr <= load_base. A CPU write in the same cycle as load_start is still performed.
  - LOAD: load_ready=1. On an edge with load_valid & load_ready, mem[load_ptr] <= load_data and load_ptr <= load_ptr+1, wrapping 63->0 modulo 2^DEPTH_LOG2. If load_last is also set, go to IDLE on that edge. load_valid=0 stalls without side effects.
- Reads: dmem_rdata = mem[dmem_addr] combinationally in IDLE and LOAD; 0 in CLEAR.
- Read and write to the same address in one cycle: dmem_rdata shows the old value; the new value is visible after the edge.
- CPU write with dmem_w_en=1 in CLEAR or LOAD: not performed; drop_cnt increments, saturating at 255.
- load_start outside IDLE is ignored, including load_start during CLEAR. The initiator waits for mem_ready.
- A burst may contain a single word: load_last on the first beat returns to IDLE after one write.
- Reset mid-CLEAR or mid-LOAD: returns asynchronously to the reset state. A partial burst is abandoned; words already written remain unless CLEAR runs again.
- drop_cnt clears only on reset.

Decomposition:
- Shared package dmem_pkg holds:
  - state encoding: CLEAR=2'd0, IDLE=2'd1, LOAD=2'd2 (2'd3 is unreachable and decodes as IDLE);
  - DMEM_DEPTH_LOG2=6;
  - DROP_CNT_MAX=8'hFF.
- One sub-module, dmem_array: WIDTH x 2^DEPTH_LOG2 storage with one synchronous write port and one asynchronous read port. The top-level FSM muxes the write-port address, data and enable among the CLEAR, IDLE and LOAD sources.

Test Plan:
- Reset clear: preload via loader, pulse reset, wait 64 cycles -> mem_ready rises on the 64th edge after release; reading address 5 gives 0; dmem_rdata=0 throughout CLEAR.
- CPU write/read: in IDLE, write 32'hDEADBEEF to address 10 -> dmem_rdata at address 10 shows the old value in the write cycle and 32'hDEADBEEF on the next cycle.
- Wrapping burst: load_start with load_base=62, then 4 beats A,B,C,D with load_last on D -> mem[62]=A, mem[63]=B, mem[0]=C, mem[1]=D; load_ready=0 and mem_ready=1 after the D edge.
- Back-pressure and drops: in LOAD, deassert load_valid for 3 cycles while the CPU asserts dmem_w_en to address 3 for those 3 cycles -> load_ptr unchanged, mem[3] unchanged, drop_cnt=3.
- Simultaneous start: in IDLE, CPU write to address 7 in the same cycle as load_start (load_base=7), first beat 32'h1 -> mem[7]=CPU data after edge 1, then 32'h1 after the beat.
- Reset mid-burst and saturation: assert reset after 2 of 5 beats -> state CLEAR, load_ready=0, drop_cnt=0. Separately, 300 dropped CPU writes -> drop_cnt=255.
